tx_reset_sequencer: RTL
=======================

Name: tx_reset_sequencer

Overview:
- Controller that sequences the RGMII TX path around link and speed changes.
- Consumes stabilized, clk-domain speed/link status from the TX clock manager's stabilizer stage.
- Drives the one-hot select of the glitch-free TX clock mux and the TX MAC reset.
- Guarantees TX reset is held before, during and after every mux switch; the mux needs at least 3 new-clock cycles to resume output.

Parameters:
PRE_RESET_CYCLES, 16, cycles reset_tx is held before the clock select changes (≥1)
MUX_SETTLE_CYCLES, 64, cycles after the select change before post-wait starts (≥1); must cover 3 cycles of 2.5 MHz at clk rate
POST_RESET_CYCLES, 32, cycles reset_tx stays asserted after mux settle (≥1)
CNT_WIDTH, 8, timer width; must hold max(parameters)-1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
speed_10  in  1  stabilized speed flag, 10 Mb/s (clk domain)
speed_100  in  1  stabilized speed flag, 100 Mb/s
speed_1000  in  1  stabilized speed flag, 1000 Mb/s
link_up  in  1  stabilized link status
clk_sel  out  3  one-hot mux select {1000,100,10}
reset_tx  out  1  TX MAC reset, active high
tx_ready  out  1  TX path running at clk_sel speed
switch_count  out  8  completed switch sequences, wraps 255→0
state_dbg  out  3  current state encoding

Behaviour:
- All outputs registered. On reset_n low (async), the block takes these values and holds them while low:
  - clk_sel=3'b100, reset_tx=1, tx_ready=0, switch_count=0
  - state=S_DOWN, timer=0, target=3'b100
- Deassertion takes effect on the next clk edge.
- speed_onehot: exactly one of {speed_1000,speed_100,speed_10} is set. Non-one-hot input is ignored and never causes a transition.
- States, with encodings for state_dbg:
  - S_DOWN(0): reset_tx=1, tx_ready=0. If link_up && speed_onehot: target<=speeds, timer<=PRE_RESET_CYCLES-1, go to S_PRE. The full sequence runs even if target==clk_sel.
  - S_PRE(1): reset_tx=1. timer decrements. At timer==0: clk_sel<=target, timer<=MUX_SETTLE_CYCLES-1, go to S_SWITCH.
  - S_SWITCH(2): reset_tx=1. At timer==0: timer<=POST_RESET_CYCLES-1, go to S_POST.
  - S_POST(3): reset_tx=1. At timer==0: reset_tx<=0, tx_ready<=1, switch_count++, go to S_RUN.
  - S_RUN(4): reset_tx=0, tx_ready=1.
    - If speed_onehot && speeds!=clk_sel: target<=speeds, reset_tx<=1, tx_ready<=0, timer<=PRE_RESET_CYCLES-1, go to S_PRE.
- Priority 1, link loss: in any non-DOWN state, !link_up → S_DOWN next edge with reset_tx=1 and tx_ready=0. clk_sel keeps its value.
- Priority 2, retarget: in S_PRE, S_SWITCH or S_POST, a one-hot speed != target loads target and reloads timer=PRE_RESET_CYCLES-1 → S_PRE. clk_sel is not changed until S_PRE expires again.
- Timing: with condition sampled at edge k (entry to S_PRE):
  - clk_sel updates at edge k+PRE_RESET_CYCLES.
  - reset_tx falls and tx_ready rises at edge k+PRE+SETTLE+POST (defaults: 16 and 112).
- Invariants:
  - clk_sel is always one-hot.
  - clk_sel changes only on the S_PRE→S_SWITCH edge, so reset_tx is 1 on the cycles before and after any clk_sel change.
  - tx_ready == !reset_tx.
- Illegal state encodings recover to S_DOWN with reset_tx=1.

Test Plan:
- Release reset_n with link_up=1, speed_1000=1 → clk_sel stays 3'b100; reset_tx falls exactly 112 clks after S_PRE entry; switch_count=1.
- From S_RUN at 1000, switch input to speed_100 → reset_tx rises next edge; clk_sel=3'b010 after 16 clks; reset_tx falls 112 clks after S_PRE entry; switch_count=2.
- Drop link_up mid-S_SWITCH → S_DOWN next edge, reset_tx=1, clk_sel unchanged, switch_count unchanged. Restore link_up → full 112-cycle sequence.
- In S_POST, change speed 100→10 → returns to S_PRE; clk_sel goes 3'b010→3'b001 only after a further 16 clks; reset_tx stays 1 throughout.
- Drive non-one-hot speeds (3'b110, 3'b000) in S_RUN and S_DOWN with link_up=1 → no state change, outputs stable.
- Assert reset_n low asynchronously mid-S_PRE (between clk edges) → outputs immediately reach reset values (clk_sel=3'b100, reset_tx=1, tx_ready=0, switch_count=0).

Source files
------------

// File: rtl/tx_reset_sequencer.sv
// Sequences the RGMII TX clock-mux select and TX MAC reset around link and speed changes.
// TX reset is held before, during and after every select change so the mux can settle.
module tx_reset_sequencer #(
    parameter int PRE_RESET_CYCLES  = 16,
    parameter int MUX_SETTLE_CYCLES = 64,
    parameter int POST_RESET_CYCLES = 32,
    parameter int CNT_WIDTH         = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       speed_10,
    input  logic       speed_100,
    input  logic       speed_1000,
    input  logic       link_up,
    output logic [2:0] clk_sel,
    output logic       reset_tx,
    output logic       tx_ready,
    output logic [7:0] switch_count,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_DOWN   = 3'd0;
    localparam logic [2:0] S_PRE    = 3'd1;
    localparam logic [2:0] S_SWITCH = 3'd2;
    localparam logic [2:0] S_POST   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] PRE_LOAD    = CNT_WIDTH'(PRE_RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(MUX_SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] POST_LOAD   = CNT_WIDTH'(POST_RESET_CYCLES - 1);

    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] timer;
    logic [2:0]           target;
    logic [2:0]           speeds;
    logic                 speed_onehot;

    assign speeds       = {speed_1000, speed_100, speed_10};
    assign speed_onehot = (speeds == 3'b001) || (speeds == 3'b010) || (speeds == 3'b100);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_DOWN;
            timer        <= '0;
            target       <= 3'b100;
            clk_sel      <= 3'b100;
            reset_tx     <= 1'b1;
            tx_ready     <= 1'b0;
            switch_count <= 8'd0;
        end else begin
            case (state)
                S_DOWN: begin
                    reset_tx <= 1'b1;
                    tx_ready <= 1'b0;
                    // Full sequence even when the link returns at the current speed
                    if (link_up && speed_onehot) begin
                        target <= speeds;
                        timer  <= PRE_LOAD;
                        state  <= S_PRE;
                    end
                end
                S_PRE, S_SWITCH, S_POST: begin
                    if (!link_up) begin
                        state    <= S_DOWN;
                        reset_tx <= 1'b1;
                        tx_ready <= 1'b0;
                    end else if (speed_onehot && speeds != target) begin
                        target <= speeds;
                        timer  <= PRE_LOAD;
                        state  <= S_PRE;
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (state == S_PRE) begin
                        // The only place the mux select ever moves
                        clk_sel <= target;
                        timer   <= SETTLE_LOAD;
                        state   <= S_SWITCH;
                    end else if (state == S_SWITCH) begin
                        timer <= POST_LOAD;
                        state <= S_POST;
                    end else begin
                        reset_tx     <= 1'b0;
                        tx_ready     <= 1'b1;
                        switch_count <= switch_count + 8'd1;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!link_up) begin
                        state    <= S_DOWN;
                        reset_tx <= 1'b1;
                        tx_ready <= 1'b0;
                    end else if (speed_onehot && speeds != clk_sel) begin
                        target   <= speeds;
                        reset_tx <= 1'b1;
                        tx_ready <= 1'b0;
                        timer    <= PRE_LOAD;
                        state    <= S_PRE;
                    end
                end
                default: begin
                    state    <= S_DOWN;
                    timer    <= '0;
                    reset_tx <= 1'b1;
                    tx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
